// File: rtl/mod_sum_checker.sv
// rtl/mod_sum_checker.sv - streaming frame sum with running residue and divisibility flag
module mod_sum_checker #(
   parameter int WIDTH = 4,
   parameter int COUNT = 4,
   parameter int MOD   = 3,
   localparam int SUM_W = WIDTH + $clog2(COUNT),
   localparam int RES_W = ($clog2(MOD) > 1) ? $clog2(MOD) : 1,
   localparam int CNT_W = $clog2(COUNT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SUM_W-1:0] out_sum,
   output logic [RES_W-1:0] out_residue,
   output logic             out_div
);

   // Residue arithmetic is done one bit wider than the residue so that
   // the modulus itself and the pre-correction sum (< 2x modulus) are representable.
   localparam int MW = WIDTH + RES_W + 1;
   localparam logic [MW-1:0]    MOD_W    = MW'(MOD);
   localparam logic [RES_W:0]   MOD_R    = (RES_W + 1)'(MOD);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

   logic [SUM_W-1:0] acc_sum;
   logic [RES_W-1:0] acc_res;
   logic [CNT_W-1:0] idx;

   logic [MW-1:0]    data_ext;
   logic [RES_W:0]   data_mod;
   logic [RES_W:0]   res_raw;
   logic [RES_W-1:0] res_next;
   logic [SUM_W-1:0] sum_next;

   logic accept;
   logic is_last;
   logic consume;

   // Input may only stall while a result is held and not being taken.
   assign in_ready = !out_valid || out_ready;
   // clear drops any operand offered in the same cycle.
   assign accept   = in_valid && in_ready && !clear;
   assign is_last  = (idx == LAST_IDX);
   assign consume  = out_valid && out_ready;

   // Next sum and residue if the current operand is accepted; the residue
   // needs at most one conditional subtraction since both terms are < MOD.
   always_comb begin
      data_ext = MW'(in_data);
      data_mod = (RES_W + 1)'(data_ext % MOD_W);
      res_raw  = {1'b0, acc_res} + data_mod;
      sum_next = acc_sum + SUM_W'(in_data);
      res_next = res_raw[RES_W-1:0];
      if (res_raw >= MOD_R) begin
         res_next = RES_W'(res_raw - MOD_R);
      end
   end

   // Running accumulators and operand index; wrap to zero on the last operand.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_sum <= '0;
         acc_res <= '0;
         idx     <= '0;
      end else if (clear) begin
         acc_sum <= '0;
         acc_res <= '0;
         idx     <= '0;
      end else if (accept) begin
         if (is_last) begin
            acc_sum <= '0;
            acc_res <= '0;
            idx     <= '0;
         end else begin
            acc_sum <= sum_next;
            acc_res <= res_next;
            idx     <= idx + CNT_W'(1);
         end
      end
   end

   // Result register: loads on the last operand (even while the previous
   // result is being consumed), otherwise holds its value after consumption.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_sum     <= '0;
         out_residue <= '0;
         out_div     <= 1'b0;
      end else begin
         if (consume) begin
            out_valid <= 1'b0;
         end
         if (accept && is_last) begin
            out_valid   <= 1'b1;
            out_sum     <= sum_next;
            out_residue <= res_next;
            out_div     <= (res_next == '0);
         end
      end
   end

endmodule

// File: tb/tb_mod_sum_checker.sv
// tb/tb_mod_sum_checker.sv - scoreboard bench for mod_sum_checker at two parameter sets
module tb_mod_sum_checker;

   typedef struct {
      int sum;
      int res;
      int dv;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Instance A: default parameters (WIDTH 4, COUNT 4, MOD 3)
   logic       a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_div;
   logic [3:0] a_in_data;
   logic [5:0] a_out_sum;
   logic [1:0] a_out_residue;

   // Instance B: WIDTH 8, COUNT 5, MOD 7
   logic        b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_div;
   logic [7:0]  b_in_data;
   logic [10:0] b_out_sum;
   logic [2:0]  b_out_residue;

   mod_sum_checker #(.WIDTH(4), .COUNT(4), .MOD(3)) dut_a (
      .clk(clk), .rst(rst), .clear(a_clear),
      .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_sum(a_out_sum), .out_residue(a_out_residue), .out_div(a_out_div)
   );

   mod_sum_checker #(.WIDTH(8), .COUNT(5), .MOD(7)) dut_b (
      .clk(clk), .rst(rst), .clear(b_clear),
      .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_sum(b_out_sum), .out_residue(b_out_residue), .out_div(b_out_div)
   );

   int compared   = 0;
   int mismatched = 0;

   exp_t qa[$];
   exp_t qb[$];
   int a_sum = 0, a_cnt = 0, a_waits = 0;
   int b_sum = 0, b_cnt = 0, b_pops = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Offer one operand to A, wait (bounded) for acceptance, update the model.
   task automatic a_op(input int d);
      int n;
      n = 0;
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_data  = 4'(d);
      #2;
      while (!a_in_ready && n < 50) begin
         @(negedge clk);
         #2;
         n++;
      end
      a_waits += n;
      if (!a_in_ready) begin
         chk("a_accept_timeout", 0, 1);
      end else begin
         a_sum += d;
         a_cnt++;
         if (a_cnt == 4) begin
            qa.push_back('{a_sum, a_sum % 3, int'(a_sum % 3 == 0)});
            a_sum = 0;
            a_cnt = 0;
         end
      end
   endtask

   task automatic a_idle();
      @(negedge clk);
      a_in_valid = 1'b0;
      #2;
   endtask

   task automatic a_chk_zero(input string tag);
      chk({tag, "_out_valid"}, a_out_valid, 0);
      chk({tag, "_out_sum"}, a_out_sum, 0);
      chk({tag, "_out_residue"}, a_out_residue, 0);
      chk({tag, "_out_div"}, a_out_div, 0);
   endtask

   task automatic b_op(input int d);
      int n;
      n = 0;
      @(negedge clk);
      b_in_valid = 1'b1;
      b_in_data  = 8'(d);
      #2;
      while (!b_in_ready && n < 200) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (!b_in_ready) begin
         chk("b_accept_timeout", 0, 1);
      end else begin
         b_sum += d;
         b_cnt++;
         if (b_cnt == 5) begin
            qb.push_back('{b_sum, b_sum % 7, int'(b_sum % 7 == 0)});
            b_sum = 0;
            b_cnt = 0;
         end
      end
   endtask

   // Monitor A: every completed output handshake is checked against the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
               chk("a_unexpected_result", 1, 0);
            end else begin
               e = qa.pop_front();
               chk("a_out_sum", a_out_sum, e.sum);
               chk("a_out_residue", a_out_residue, e.res);
               chk("a_out_div", a_out_div, e.dv);
            end
         end
      end
   end

   // Monitor B: randomises out_ready and checks each handshake.
   initial begin
      exp_t e;
      b_out_ready = 1'b1;
      forever begin
         @(negedge clk);
         b_out_ready = ($urandom_range(0, 9) < 7);
         #1;
         if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
               chk("b_unexpected_result", 1, 0);
            end else begin
               e = qb.pop_front();
               chk("b_out_sum", b_out_sum, e.sum);
               chk("b_out_residue", b_out_residue, e.res);
               chk("b_out_div", b_out_div, e.dv);
               if (b_pops == 0) begin
                  chk("b_255x5_sum", b_out_sum, 1275);
                  chk("b_255x5_residue", b_out_residue, 1);
                  chk("b_255x5_div", b_out_div, 0);
               end
               b_pops++;
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      a_clear = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 1;
      b_clear = 0; b_in_valid = 0; b_in_data = 0;
      rst = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      #2;
      a_chk_zero("rst_hold");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #2;
      chk("rst_in_ready", a_in_ready, 1);
      a_chk_zero("rst_after");

      // Frame 4,5,6,9: result one cycle after last accept, then drops
      a_op(4); a_op(5); a_op(6); a_op(9);
      a_idle();
      chk("t1_latency_valid", a_out_valid, 1);
      a_idle();
      chk("t1_valid_drop", a_out_valid, 0);
      chk("t1_sum_held", a_out_sum, 24);

      // Back-to-back frames without a bubble
      a_waits = 0;
      for (int i = 0; i < 4; i++) a_op(15);
      a_op(1);
      chk("t2_first_result_valid", a_out_valid, 1);
      a_op(0); a_op(0); a_op(0);
      chk("t2_no_bubble_waits", a_waits, 0);
      a_idle();
      chk("t2_second_valid", a_out_valid, 1);
      a_idle();

      // Backpressure: result held, input stalled, offered operands ignored
      a_out_ready = 1'b0;
      a_op(3); a_op(3); a_op(3); a_op(2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         a_in_valid = 1'b1;
         a_in_data  = 4'd5;
         #2;
         chk("t3_in_ready_low", a_in_ready, 0);
         chk("t3_valid_stable", a_out_valid, 1);
         chk("t3_sum_stable", a_out_sum, 11);
         chk("t3_res_stable", a_out_residue, 2);
         chk("t3_div_stable", a_out_div, 0);
      end
      @(negedge clk);
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      #2;
      chk("t3_in_ready_release", a_in_ready, 1);
      a_op(5); a_op(1); a_op(0); a_op(0);
      a_idle(); a_idle();

      // clear mid-frame drops the partial frame and the same-cycle operand
      a_op(7); a_op(8);
      @(negedge clk);
      a_clear = 1'b1; a_in_valid = 1'b1; a_in_data = 4'd9;
      @(negedge clk);
      a_clear = 1'b0; a_in_valid = 1'b0;
      a_sum = 0; a_cnt = 0;
      for (int i = 0; i < 4; i++) a_op(3);
      a_idle(); a_idle();

      // Reset mid-frame
      a_op(1); a_op(1); a_op(1);
      @(negedge clk);
      a_in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      #2;
      a_chk_zero("t5_during");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #2;
      a_chk_zero("t5_after");
      chk("t5_in_ready", a_in_ready, 1);
      a_sum = 0; a_cnt = 0;
      a_op(1); a_op(2); a_op(3); a_op(6);
      a_idle(); a_idle();

      // Random frames on B, first frame is 255 x 5
      for (int f = 0; f < 1000; f++) begin
         for (int k = 0; k < 5; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               @(negedge clk);
               b_in_valid = 1'b0;
            end
            b_op((f == 0) ? 255 : int'($urandom_range(0, 255)));
         end
      end
      @(negedge clk);
      b_in_valid = 1'b0;

      n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);
      chk("b_frames_seen", b_pops, 1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
